// File: rtl/coef_ram_writer.sv
// -----------------------------------------------------------------------------
// coef_ram_writer
//
// Loads a coefficient table of N_ADDR words from a streaming source into
// on-chip RAM. It offers the same registered read port as the coefficient
// ROMs, so the datapath can use it in their place for runtime-reloadable
// weights. A load FSM generates the write address and checks the frame
// length. It flags short frames (din_last arrives early) and overlong frames
// (more than N_ADDR words).
//
// Optional feature macro: DOUBLE_BUFFER_EN
//   defined   : two RAM banks. Reads use bank_sel and loads write the other
//               bank. bank_sel flips when a load completes cleanly.
//   undefined : a single bank. bank_sel is tied to 0, and reads during a load
//               can return a mix of old and new words.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high (control and wout only; RAM kept)
//   load_start  one-cycle pulse; begins or restarts a table load
//   din         coefficient word
//   din_valid   din is valid this cycle (no backpressure)
//   din_last    final word of a frame, qualified by din_valid
//   ren         read enable
//   radd        read address
//   wout        registered read data, 1-cycle latency, read-first on collision
//   busy        high while in LOAD or FLUSH
//   done        one-cycle pulse after a full, correct table has been written
//   err         sticky frame error; cleared by load_start or rst
//   wr_count    words written in the current or last load (saturates at N_ADDR)
//   bank_sel    active read bank
// -----------------------------------------------------------------------------
module coef_ram_writer #(
    parameter int N_ADDR     = 256,
    parameter int DATA_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_start,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic                        din_valid,
    input  logic                        din_last,
    input  logic                        ren,
    input  logic [$clog2(N_ADDR)-1:0]   radd,
    output logic [DATA_WIDTH-1:0]       wout,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [$clog2(N_ADDR):0]     wr_count,
    output logic                        bank_sel
);

    localparam int AW = $clog2(N_ADDR);
    localparam int CW = AW + 1;

`ifdef DOUBLE_BUFFER_EN
    localparam int BANKS = 2;
`else
    localparam int BANKS = 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [AW-1:0]          waddr, waddr_nxt;
    logic                   full, full_nxt;
    logic [CW-1:0]          cnt_nxt;
    logic                   err_nxt;
    logic                   done_nxt;
    logic                   we;
    logic [AW-1:0]          wa;

    // Working copies of the load context. A restart zeroes them before the
    // word that arrives in the same cycle is processed, so that word lands at
    // address 0 of the new load.
    logic [AW-1:0]          lw_addr;
    logic                   lw_full;
    logic [CW-1:0]          lw_cnt;
    logic                   in_load;

    logic [DATA_WIDTH-1:0]  mem [BANKS*N_ADDR];

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v >= CW'(N_ADDR))
            return CW'(N_ADDR);
        else
            return v + 1'b1;
    endfunction

    // ---- next-state / datapath control ----
    always_comb begin
        state_nxt = state;
        waddr_nxt = waddr;
        full_nxt  = full;
        cnt_nxt   = wr_count;
        err_nxt   = err;
        done_nxt  = 1'b0;
        we        = 1'b0;
        wa        = waddr;
        lw_addr   = waddr;
        lw_full   = full;
        lw_cnt    = wr_count;
        in_load   = 1'b0;

        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = LOAD;
                    waddr_nxt = '0;
                    full_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                end
            end
            LOAD, FLUSH: begin
                if (load_start) begin
                    state_nxt = LOAD;
                    waddr_nxt = '0;
                    full_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                    lw_addr   = '0;
                    lw_full   = 1'b0;
                    lw_cnt    = '0;
                    in_load   = 1'b1;
                end else if (state == LOAD) begin
                    in_load = 1'b1;
                end else if (din_valid && din_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (in_load && din_valid) begin
            if (lw_full) begin
                // Overlong frame: drop the word and drain to din_last.
                err_nxt   = 1'b1;
                state_nxt = din_last ? IDLE : FLUSH;
            end else begin
                we        = 1'b1;
                wa        = lw_addr;
                waddr_nxt = lw_addr + 1'b1;
                cnt_nxt   = sat_inc(lw_cnt);
                if (lw_addr == AW'(N_ADDR - 1)) begin
                    if (din_last) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        full_nxt  = 1'b1;
                    end
                end else if (din_last) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
        end
    end

    // ---- control registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            waddr    <= '0;
            full     <= 1'b0;
            wr_count <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            waddr    <= waddr_nxt;
            full     <= full_nxt;
            wr_count <= cnt_nxt;
            err      <= err_nxt;
            done     <= done_nxt;
        end
    end

    assign busy = (state != IDLE);

`ifdef DOUBLE_BUFFER_EN
    logic [AW:0] wr_idx, rd_idx;
    assign wr_idx = {~bank_sel, wa};
    assign rd_idx = {bank_sel, radd};

    // Flip on the same edge that raises done, so reads issued from the
    // done cycle onward see the new table.
    always_ff @(posedge clk) begin
        if (rst)
            bank_sel <= 1'b0;
        else if (done_nxt)
            bank_sel <= ~bank_sel;
    end
`else
    logic [AW-1:0] wr_idx, rd_idx;
    assign wr_idx   = wa;
    assign rd_idx   = radd;
    assign bank_sel = 1'b0;
`endif

    // ---- RAM write (contents survive reset) ----
    always_ff @(posedge clk) begin
        if (we && !rst)
            mem[wr_idx] <= din;
    end

    // ---- registered read port, read-first ----
    always_ff @(posedge clk) begin
        if (rst)
            wout <= '0;
        else if (ren)
            wout <= mem[rd_idx];
    end

endmodule

// File: tb/tb_coef_ram_writer.sv
module tb_coef_ram_writer;

    localparam int N  = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_last;
    logic          ren;
    logic [2:0]    radd;
    logic [DW-1:0] wout;
    logic          busy;
    logic          done;
    logic          err;
    logic [3:0]    wr_count;
    logic          bank_sel;

    always #5 clk = ~clk;

    coef_ram_writer #(.N_ADDR(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .din(din),
        .din_valid(din_valid), .din_last(din_last), .ren(ren), .radd(radd),
        .wout(wout), .busy(busy), .done(done), .err(err),
        .wr_count(wr_count), .bank_sel(bank_sel)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    int            done_cnt = 0;
    int            d0;
    logic [DW-1:0] sb_q[$];
    logic          rd_s;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Read scoreboard and done monitor, sampled 2 time units after each edge.
    always @(posedge clk) begin
        rd_s = ren && !rst;
        #2;
        if (done) begin
            done_cnt++;
            check_eq("done_err_excl", {31'b0, err}, 32'd0);
        end
        if (rd_s) begin
            if (sb_q.size() == 0)
                check_eq("rd_unexpected", sb_q.size(), 32'd1);
            else
                check_eq("rd_data", {16'b0, wout}, {16'b0, sb_q.pop_front()});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        din       = d;
        din_valid = 1'b1;
        din_last  = last;
        tick();
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic rd(input int a, input logic [DW-1:0] e);
        ren  = 1'b1;
        radd = a[2:0];
        sb_q.push_back(e);
        tick();
        ren  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_start = 1'b0; din = '0; din_valid = 1'b0;
        din_last = 1'b0; ren = 1'b0; radd = '0;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_wout", {16'b0, wout}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_err", {31'b0, err}, 32'd0);
        check_eq("rst_wr_count", {28'b0, wr_count}, 32'd0);
        check_eq("rst_bank_sel", {31'b0, bank_sel}, 32'd0);

        // Normal load
        d0 = done_cnt;
        pulse_start();
        check_eq("norm_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < N; i++) send(16'h0100 + 16'(i), i == N - 1);
        check_eq("norm_done", {31'b0, done}, 32'd1);
        check_eq("norm_err", {31'b0, err}, 32'd0);
        check_eq("norm_wr_count", {28'b0, wr_count}, 32'd8);
        check_eq("norm_busy_end", {31'b0, busy}, 32'd0);
        tick();
        check_eq("norm_done_pulse", {31'b0, done}, 32'd0);
        check_eq("norm_done_cnt", done_cnt, d0 + 1);
        for (int i = 0; i < N; i++) rd(i, 16'h0100 + 16'(i));
        tick();

        // Short frame
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 5; i++) send(16'h0200 + 16'(i), i == 4);
        check_eq("short_err", {31'b0, err}, 32'd1);
        check_eq("short_done", {31'b0, done}, 32'd0);
        check_eq("short_wr_count", {28'b0, wr_count}, 32'd5);
        check_eq("short_busy", {31'b0, busy}, 32'd0);
`ifndef DOUBLE_BUFFER_EN
        rd(4, 16'h0204);
        rd(5, 16'h0105);
`endif
        tick();
        check_eq("short_done_cnt", done_cnt, d0);

        // Overlong frame
        d0 = done_cnt;
        pulse_start();
        check_eq("long_err_clr", {31'b0, err}, 32'd0);
        for (int i = 0; i < 9; i++) send(16'h0300 + 16'(i), 1'b0);
        check_eq("long_err_flush", {31'b0, err}, 32'd1);
        check_eq("long_busy_flush", {31'b0, busy}, 32'd1);
        send(16'h0309, 1'b1);
        check_eq("long_err", {31'b0, err}, 32'd1);
        check_eq("long_busy", {31'b0, busy}, 32'd0);
        check_eq("long_wr_count", {28'b0, wr_count}, 32'd8);
`ifndef DOUBLE_BUFFER_EN
        rd(0, 16'h0300);
        rd(7, 16'h0307);
`endif
        tick();
        check_eq("long_done_cnt", done_cnt, d0);

        // Gapped valid plus restart
        d0 = done_cnt;
        pulse_start();
        check_eq("gap_err_clr", {31'b0, err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            send(16'h0400 + 16'(i), 1'b0);
            tick();
        end
        check_eq("gap_wr_count3", {28'b0, wr_count}, 32'd3);
        load_start = 1'b1; din = 16'h0500; din_valid = 1'b1; din_last = 1'b0;
        tick();
        load_start = 1'b0; din_valid = 1'b0;
        check_eq("restart_wr_count", {28'b0, wr_count}, 32'd1);
        check_eq("restart_busy", {31'b0, busy}, 32'd1);
        for (int i = 1; i < N; i++) begin
            tick();
            send(16'h0500 + 16'(i), i == N - 1);
        end
        check_eq("gap_done", {31'b0, done}, 32'd1);
        check_eq("gap_wr_count", {28'b0, wr_count}, 32'd8);
        tick();
        check_eq("gap_done_cnt", done_cnt, d0 + 1);
        for (int i = 0; i < N; i++) rd(i, 16'h0500 + 16'(i));

`ifndef DOUBLE_BUFFER_EN
        // Read/write collision at address 2
        pulse_start();
        send(16'h0600, 1'b0);
        send(16'h0601, 1'b0);
        din = 16'hBEEF; din_valid = 1'b1; ren = 1'b1; radd = 3'd2;
        sb_q.push_back(16'h0502);
        tick();
        din_valid = 1'b0;
        rd(2, 16'hBEEF);
        for (int i = 3; i < N; i++) send(16'h0600 + 16'(i), i == N - 1);
        check_eq("coll_done", {31'b0, done}, 32'd1);
`endif
        tick();

        // Reset mid-load
        pulse_start();
        for (int i = 0; i < 4; i++) send(16'h0700 + 16'(i), 1'b0);
        check_eq("rstm_busy_pre", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rstm_busy", {31'b0, busy}, 32'd0);
        check_eq("rstm_err", {31'b0, err}, 32'd0);
        check_eq("rstm_wr_count", {28'b0, wr_count}, 32'd0);
        check_eq("rstm_bank_sel", {31'b0, bank_sel}, 32'd0);
        check_eq("rstm_wout", {16'b0, wout}, 32'd0);
`ifndef DOUBLE_BUFFER_EN
        rd(0, 16'h0700);
        rd(5, 16'h0605);
`else
        // Double buffer: load A, then load B while reading A
        pulse_start();
        for (int i = 0; i < N; i++) send(16'h0A00 + 16'(i), i == N - 1);
        check_eq("db_a_done", {31'b0, done}, 32'd1);
        check_eq("db_a_bank", {31'b0, bank_sel}, 32'd1);
        pulse_start();
        for (int i = 0; i < N; i++) begin
            din = 16'h0B00 + 16'(i); din_valid = 1'b1; din_last = (i == N - 1);
            ren = 1'b1; radd = 3'(i);
            sb_q.push_back(16'h0A00 + 16'(i));
            tick();
        end
        din_valid = 1'b0; din_last = 1'b0; ren = 1'b0;
        check_eq("db_b_done", {31'b0, done}, 32'd1);
        check_eq("db_b_bank", {31'b0, bank_sel}, 32'd0);
        rd(0, 16'h0B00);
        rd(7, 16'h0B07);
`endif
        tick(); tick();
        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
